// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares the single-port data memory between the core (C) and DMA/debug (D) ports.
// One transaction in flight: grant in IDLE, one-cycle memory access, one-cycle response.
module dmem_arbiter #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  c_req,
   input  logic                  c_we,
   input  logic [DM_ADDRESS-1:0] c_addr,
   input  logic [DATA_W-1:0]     c_wdata,
   input  logic [2:0]            c_funct3,
   output logic                  c_gnt,
   output logic                  c_rvalid,
   output logic                  c_err,
   output logic [DATA_W-1:0]     c_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [DM_ADDRESS-1:0] d_addr,
   input  logic [DATA_W-1:0]     d_wdata,
   input  logic [2:0]            d_funct3,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic                  d_err,
   output logic [DATA_W-1:0]     d_rdata,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [DM_ADDRESS-1:0] mem_addr,
   output logic [DATA_W-1:0]     mem_wd,
   output logic [2:0]            mem_funct3,
   input  logic [DATA_W-1:0]     mem_rd,
   output logic [1:0]            fsm_state
);

   // Handshake: a requester holds req and its fields stable until it sees gnt high at a
   // rising edge; rvalid (qualified by err) is a single-cycle pulse to the owner only.

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                state;
   logic                  rr_last;   // 1 = D was granted last
   logic                  own;       // 1 = D owns the transaction
   logic                  l_we;
   logic                  l_err;
   logic [DM_ADDRESS-1:0] l_addr;
   logic [DATA_W-1:0]     l_wdata;
   logic [2:0]            l_funct3;

   logic                  pick_d;
   logic                  take;
   logic                  sel_we;
   logic [DM_ADDRESS-1:0] sel_addr;
   logic [DATA_W-1:0]     sel_wdata;
   logic [2:0]            sel_funct3;
   logic                  mem_active;

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
      logic bad;
      bad = 1'b0;
      if (f3 == 3'b010 && a != 2'b00)
         bad = 1'b1;
      else if ((f3 == 3'b001 || f3 == 3'b101) && a[0])
         bad = 1'b1;
      return bad;
   endfunction

   always_comb begin
      pick_d     = d_req && (!c_req || !rr_last);
      take       = (state == IDLE) && (c_req || d_req) && !reset;
      sel_we     = pick_d ? d_we     : c_we;
      sel_addr   = pick_d ? d_addr   : c_addr;
      sel_wdata  = pick_d ? d_wdata  : c_wdata;
      sel_funct3 = pick_d ? d_funct3 : c_funct3;
   end

   assign c_gnt = take && !pick_d;
   assign d_gnt = take && pick_d;

   // Strobes are gated by reset so an in-flight write is dropped in the cycle reset arrives.
   assign mem_active = (state == ACCESS) && !l_err && !reset;
   assign mem_read   = mem_active && !l_we;
   assign mem_write  = mem_active && l_we;
   assign mem_addr   = mem_active ? l_addr   : '0;
   assign mem_wd     = mem_active ? l_wdata  : '0;
   assign mem_funct3 = mem_active ? l_funct3 : '0;
   assign fsm_state  = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         rr_last  <= 1'b1;
         own      <= 1'b0;
         l_we     <= 1'b0;
         l_err    <= 1'b0;
         l_addr   <= '0;
         l_wdata  <= '0;
         l_funct3 <= '0;
         c_rvalid <= 1'b0;
         c_err    <= 1'b0;
         c_rdata  <= '0;
         d_rvalid <= 1'b0;
         d_err    <= 1'b0;
         d_rdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (c_req || d_req) begin
                  own      <= pick_d;
                  rr_last  <= pick_d;
                  l_we     <= sel_we;
                  l_addr   <= sel_addr;
                  l_wdata  <= sel_wdata;
                  l_funct3 <= sel_funct3;
                  l_err    <= misaligned(sel_funct3, sel_addr[1:0]);
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               if (!l_err && !l_we) begin
                  if (own) d_rdata <= mem_rd;
                  else     c_rdata <= mem_rd;
               end
               c_rvalid <= !own;
               c_err    <= !own && l_err;
               d_rvalid <= own;
               d_err    <= own && l_err;
               state    <= RESP;
            end
            RESP: begin
               c_rvalid <= 1'b0;
               c_err    <= 1'b0;
               d_rvalid <= 1'b0;
               d_err    <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a word memory model, a request driver, and a response
// scoreboard whose monitor checks owner, err, rdata and arrival cycle of every rvalid.
module tb_dmem_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int EW = 50;  // {due[15:0], port, err, rdata[31:0]}

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req, c_we, d_req, d_we;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata;
  logic [2:0]    c_funct3, d_funct3;
  logic          c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
  logic [DW-1:0] c_rdata, d_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd, mem_rd;
  logic [2:0]    mem_funct3;
  logic [1:0]    fsm_state;

  logic [DW-1:0] mem_arr [0:127];
  logic [EW-1:0] exp_q[$];
  int            cyc = 0;
  int            n_chk = 0;
  int            n_fail = 0;
  int            c_act = 0;

  dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_funct3(c_funct3),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_err(c_err), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_funct3(mem_funct3), .mem_rd(mem_rd), .fsm_state(fsm_state)
  );

  // clock / reset / memory model
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_rd = mem_arr[mem_addr[8:2]];
  always @(posedge clk) if (mem_write) mem_arr[mem_addr[8:2]] <= mem_wd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (c_gnt || c_rvalid || c_err || (c_rdata != '0)) c_act++;
    if (mem_read || mem_write) chk("strobe_exclusive", {mem_read, mem_write} == 2'b11, 0);
    if (c_rvalid || d_rvalid) begin
      chk("rvalid_one_owner", c_rvalid && d_rvalid, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", {c_rvalid, d_rvalid}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_port", d_rvalid, e[33]);
        chk("resp_err", d_rvalid ? d_err : c_err, e[32]);
        chk("other_err", d_rvalid ? c_err : d_err, 0);
        chk("resp_rdata", d_rvalid ? d_rdata : c_rdata, e[31:0]);
        chk("resp_cycle", cyc, e[49:34]);
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", exp_q.size(), 0);
  endtask

  task automatic xact(input logic port, input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [2:0] f3,
                      input logic exp_err, input logic [DW-1:0] exp_rdata);
    int  n = 0;
    logic got = 1'b0;
    @(posedge clk); #1;
    if (port) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_funct3 = f3;
    end else begin
      c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata; c_funct3 = f3;
    end
    while (!got && n < 20) begin
      @(negedge clk);
      got = port ? d_gnt : c_gnt;
      n++;
    end
    chk("grant_seen", got, 1);
    if (!got) begin
      c_req = 1'b0; d_req = 1'b0;
      return;
    end
    chk("grant_other_zero", port ? c_gnt : d_gnt, 0);
    exp_q.push_back({16'(cyc + 2), port, exp_err, exp_rdata});
    chk("strobes_at_grant", {mem_read, mem_write}, 0);
    @(posedge clk); #1;
    c_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("mem_read_t1", mem_read, !we && !exp_err);
    chk("mem_write_t1", mem_write, we && !exp_err);
    if (!exp_err) begin
      chk("mem_addr_t1", mem_addr, addr);
      chk("mem_funct3_t1", mem_funct3, f3);
      if (we) chk("mem_wd_t1", mem_wd, wdata);
    end
    @(negedge clk);
    chk("strobes_t2", {mem_read, mem_write}, 0);
    wait_drain();
  endtask

  initial begin
    int last_g;
    int n;
    int snap;
    logic got_c, got_d;
    reset = 1'b1;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0; c_funct3 = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_funct3 = '0;
    for (int i = 0; i < 128; i++) mem_arr[i] = '0;
    mem_arr[127] = 32'h1234_5678;  // byte address 0x1FC

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", {c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err, mem_read, mem_write}, 0);
    chk("reset_rdata", {c_rdata, d_rdata}, 0);
    chk("reset_mem_bus", {mem_addr, mem_wd, mem_funct3}, 0);
    chk("reset_state", fsm_state, 0);
    #1 reset = 1'b0;

    // 1: core store then load
    xact(1'b0, 1'b1, 9'h010, 32'hDEAD_BEEF, 3'b010, 1'b0, 32'h0);
    xact(1'b0, 1'b0, 9'h010, 32'h0, 3'b010, 1'b0, 32'hDEAD_BEEF);
    // 6: store leaves c_rdata holding the last load
    xact(1'b0, 1'b1, 9'h020, 32'hCAFE_0001, 3'b010, 1'b0, 32'hDEAD_BEEF);
    chk("mem_0x020_written", mem_arr[8], 32'hCAFE_0001);
    // 3: misaligned word load, and a misaligned halfword
    xact(1'b0, 1'b0, 9'h012, 32'h0, 3'b010, 1'b1, 32'hDEAD_BEEF);
    xact(1'b0, 1'b0, 9'h011, 32'h0, 3'b101, 1'b1, 32'hDEAD_BEEF);

    // 4: D-only load, core side silent
    do_reset();
    snap = c_act;
    xact(1'b1, 1'b0, 9'h1FC, 32'h0, 3'b010, 1'b0, 32'h1234_5678);
    chk("core_silent", c_act - snap, 0);

    // 2: both held continuously after reset -> C, D, C, D, 3 cycles apart
    do_reset();
    @(posedge clk); #1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 9'h010; c_funct3 = 3'b010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'h1FC; d_funct3 = 3'b010;
    last_g = 0;
    for (int g = 0; g < 4; g++) begin
      n = 0; got_c = 0; got_d = 0;
      while (!(got_c || got_d) && n < 10) begin
        @(negedge clk);
        got_c = c_gnt; got_d = d_gnt;
        n++;
      end
      chk("rr_grant_seen", got_c || got_d, 1);
      chk("rr_winner", {got_c, got_d}, (g % 2 == 0) ? 2'b10 : 2'b01);
      if (g > 0) chk("rr_spacing", cyc - last_g, 3);
      last_g = cyc;
      exp_q.push_back({16'(cyc + 2), got_d, 1'b0, got_d ? 32'h1234_5678 : 32'hDEAD_BEEF});
      if (g == 3) begin
        @(posedge clk); #1;
        c_req = 1'b0; d_req = 1'b0;
      end
    end
    wait_drain();

    // 5: reset during the ACCESS of a store, D pending
    @(posedge clk); #1;
    c_req = 1'b1; c_we = 1'b1; c_addr = 9'h030; c_wdata = 32'hAAAA_5555; c_funct3 = 3'b010;
    @(negedge clk);
    chk("abort_grant", c_gnt, 1);
    @(posedge clk); #1;
    c_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'h010; d_funct3 = 3'b010;
    @(negedge clk);
    chk("abort_write_active", mem_write, 1);
    #1 reset = 1'b1;
    #1 chk("abort_write_drop", mem_write, 0);
    @(negedge clk);
    chk("abort_state_idle", fsm_state, 0);
    chk("abort_no_gnt_in_reset", d_gnt, 0);
    chk("abort_mem_untouched", mem_arr[12], 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("post_reset_d_gnt", {c_gnt, d_gnt}, 2'b01);
    if (d_gnt) exp_q.push_back({16'(cyc + 2), 1'b1, 1'b0, 32'hDEAD_BEEF});
    @(posedge clk); #1 d_req = 1'b0;
    wait_drain();

    repeat (4) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
